io_input_conditioner: RTL and testbench
=======================================

// Module: io_input_conditioner
// PURPOSE
//  Conditions asynchronous external input pins before the memory-mapped I/O buffer samples them as PORT_A/PORT_B.
//  - Double-flop synchronises the whole input word.
//  - Debounces it as one unit: a new value is accepted only after it has been stable for DEBOUNCE_CYCLES.
//  - Records sticky per-bit rising-edge flags that software can clear.
//  - One instance sits directly upstream of each input port of the I/O buffer.
// PARAMETERS
//  WIDTH            32  width of the pin word / PORT_OUT
//  DEBOUNCE_CYCLES  4   stable cycles required before commit; legal range >=1
//  CNT_W            $clog2(DEBOUNCE_CYCLES)+1  counter width (derived, do not override)
// PORTS
//  CLK        in   1      system clock, rising edge
//  RST        in   1      asynchronous active-low reset
//  PIN_IN     in   WIDTH  raw asynchronous pin levels
//  CLR_EDGES  in   WIDTH  per-bit clear mask for EDGE_FLAGS; synchronous, one-cycle pulse
//  PORT_OUT   out  WIDTH  debounced word; drives the I/O buffer input port
//  EDGE_FLAGS out  WIDTH  sticky rising-edge flags of PORT_OUT
//  CHANGED    out  1      one-cycle pulse on every commit that alters PORT_OUT
// BEHAVIOUR
//  Reset (RST low, asynchronous):
//   - Clears sync1, sync2, cand, PORT_OUT, EDGE_FLAGS, cnt and CHANGED to 0; state=IDLE.
//   - Reset applied mid-settle abandons the pending value; no commit and no pulse.
//  Synchroniser:
//   - sync1<=PIN_IN; sync2<=sync1.
//   - Only sync2 feeds the logic below.
//  FSM states: IDLE, SETTLE. Registers cand[WIDTH], cnt[CNT_W].
//  IDLE:
//   - sync2==PORT_OUT: hold.
//   - Otherwise: cand<=sync2, cnt<=0, go to SETTLE.
//  SETTLE (priority order):
//   1. sync2==PORT_OUT: return to IDLE, cnt<=0. No commit, no CHANGED (bounce back).
//   2. sync2!=cand: cand<=sync2, cnt<=0, stay in SETTLE (restart).
//   3. cnt==DEBOUNCE_CYCLES-1: commit, go to IDLE, cnt<=0.
//   4. Otherwise: cnt<=cnt+1.
//  Commit, all on the same edge:
//   - PORT_OUT<=cand.
//   - CHANGED<=1 for exactly one cycle (0 on all other cycles).
//   - EDGE_FLAGS set bits where cand & ~PORT_OUT.
//   - Falling edges set no flags.
//  EDGE_FLAGS update rule:
//   - Each cycle: EDGE_FLAGS <= (EDGE_FLAGS & ~CLR_EDGES) | rise_set.
//   - Set dominates clear when both hit the same bit in the same cycle.
//  Latency:
//   - Pins change and are stable from before edge E0; PORT_OUT/CHANGED/EDGE_FLAGS update on edge E0+DEBOUNCE_CYCLES+2.
//   - DEBOUNCE_CYCLES=1 gives E0+3.
//  Width and bound rules:
//   - cnt never exceeds DEBOUNCE_CYCLES-1; no wrap.
//   - Comparisons are full WIDTH.
//   - Several bits changing together commit as one word and one pulse.
//  Outputs are registered only; no combinational path from PIN_IN or CLR_EDGES to any output.
// TESTING (WIDTH=32, DEBOUNCE_CYCLES=4)
//  1. Reset:
//     - Hold RST low with PIN_IN=FFFFFFFF -> all outputs 0.
//     - Release -> PORT_OUT=FFFFFFFF at release+6 edges, CHANGED pulses once, EDGE_FLAGS=FFFFFFFF.
//  2. Clean rise:
//     - PIN_IN 0->00000001 before E0 -> PORT_OUT=00000001 at E0+6, CHANGED high for exactly cycle E0+6, EDGE_FLAGS[0]=1.
//  3. Glitch:
//     - PIN_IN=00000010 for 3 cycles, then back to 0 -> PORT_OUT, EDGE_FLAGS and CHANGED never change.
//  4. Bounce:
//     - PIN_IN toggles 00000100/00000000 every 2 cycles for 10 cycles, then holds 00000100 from E1 -> single commit at E1+6, one CHANGED pulse.
//  5. Clear vs set:
//     - With EDGE_FLAGS[0]=1, pulse CLR_EDGES=00000001 -> flag 0 next cycle.
//     - Repeat with CLR_EDGES on the commit edge of a new rise of bit0 -> flag stays 1.
//  6. Falling edge and reset mid-settle:
//     - PORT_OUT 00000001->0 -> CHANGED pulses, EDGE_FLAGS unchanged.
//     - Assert RST 2 cycles into SETTLE -> all 0, no CHANGED.

Source files
------------

// File: rtl/io_input_conditioner.sv
// Input pin conditioner: double-flop synchroniser, whole-word debouncer and
// sticky per-bit rising-edge flags feeding one I/O buffer input port.
module io_input_conditioner #(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] PIN_IN,
    input  logic [WIDTH-1:0] CLR_EDGES,
    output logic [WIDTH-1:0] PORT_OUT,
    output logic [WIDTH-1:0] EDGE_FLAGS,
    output logic             CHANGED
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        SETTLE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] rise_set;
    logic [CNT_W-1:0] cnt;
    logic             load_cand;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             commit;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sync2 != PORT_OUT) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (sync2 == PORT_OUT) begin
                    state_nxt = IDLE;
                end else if (sync2 != cand) begin
                    state_nxt = SETTLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control decode; priority in SETTLE is bounce-back, restart, commit, count
    always_comb begin
        load_cand = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (sync2 != PORT_OUT) begin
                    load_cand = 1'b1;
                    cnt_clr   = 1'b1;
                end
            end
            SETTLE: begin
                if (sync2 == PORT_OUT) begin
                    cnt_clr = 1'b1;
                end else if (sync2 != cand) begin
                    load_cand = 1'b1;
                    cnt_clr   = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    commit  = 1'b1;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: ;
        endcase
        rise_set = commit ? (cand & ~PORT_OUT) : '0;
    end

    // Synchroniser and datapath registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1      <= '0;
            sync2      <= '0;
            cand       <= '0;
            cnt        <= '0;
            PORT_OUT   <= '0;
            EDGE_FLAGS <= '0;
            CHANGED    <= 1'b0;
        end else begin
            sync1 <= PIN_IN;
            sync2 <= sync1;
            if (load_cand) begin
                cand <= sync2;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (commit) begin
                PORT_OUT <= cand;
            end
            CHANGED    <= commit;
            // Set wins over a simultaneous clear of the same bit
            EDGE_FLAGS <= (EDGE_FLAGS & ~CLR_EDGES) | rise_set;
        end
    end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with a run-length debounce model
// checked every cycle, plus hand-computed literal checkpoints.
module tb_io_input_conditioner;

    localparam int W = 32;
    localparam int D = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] PIN_IN;
    logic [W-1:0] CLR_EDGES;
    logic [W-1:0] PORT_OUT;
    logic [W-1:0] EDGE_FLAGS;
    logic         CHANGED;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses;

    io_input_conditioner #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PIN_IN    (PIN_IN),
        .CLR_EDGES (CLR_EDGES),
        .PORT_OUT  (PORT_OUT),
        .EDGE_FLAGS(EDGE_FLAGS),
        .CHANGED   (CHANGED)
    );

    always #5 CLK = ~CLK;

    // Model: hist[i] is the pin word sampled i+1 edges ago. The logic sees a
    // pin word two edges late and accepts it once D+1 consecutive observations
    // agree and differ from the current output.
    logic [W-1:0] hist [0:D+1];
    logic [W-1:0] m_port;
    logic [W-1:0] m_flags;
    logic         m_changed;
    logic [W-1:0] m_obs;
    logic         m_commit;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i <= D + 1; i++) hist[i] <= '0;
            m_port    <= '0;
            m_flags   <= '0;
            m_changed <= 1'b0;
        end else begin
            m_obs    = hist[1];
            m_commit = (m_obs != m_port);
            for (int i = 2; i <= D + 1; i++)
                if (hist[i] != m_obs) m_commit = 1'b0;
            m_changed <= m_commit;
            m_flags   <= (m_flags & ~CLR_EDGES) | (m_commit ? (m_obs & ~m_port) : '0);
            if (m_commit) m_port <= m_obs;
            hist[0] <= PIN_IN;
            for (int i = 1; i <= D + 1; i++) hist[i] <= hist[i-1];
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare the DUT against the model
    task automatic tick();
        @(negedge CLK);
        chk("model_port", PORT_OUT, m_port);
        chk("model_flags", EDGE_FLAGS, m_flags);
        chk("model_changed", {31'd0, CHANGED}, {31'd0, m_changed});
        if (CHANGED) pulses++;
    endtask

    initial begin
        RST       = 1'b0;
        PIN_IN    = 32'hFFFF_FFFF;
        CLR_EDGES = '0;
        pulses    = 0;

        // Reset with all pins high
        repeat (3) tick();
        chk("rst_port", PORT_OUT, 32'h0);
        chk("rst_flags", EDGE_FLAGS, 32'h0);
        chk("rst_changed", {31'd0, CHANGED}, 32'h0);
        RST = 1'b1;
        repeat (6) tick();
        chk("rel_port_early", PORT_OUT, 32'h0);
        tick();
        chk("rel_port", PORT_OUT, 32'hFFFF_FFFF);
        chk("rel_changed", {31'd0, CHANGED}, 32'h1);
        chk("rel_flags", EDGE_FLAGS, 32'hFFFF_FFFF);
        tick();
        chk("rel_changed_off", {31'd0, CHANGED}, 32'h0);

        // Fall to zero, then clear all flags
        PIN_IN = '0;
        repeat (8) tick();
        chk("fall_flags_kept", EDGE_FLAGS, 32'hFFFF_FFFF);
        CLR_EDGES = 32'hFFFF_FFFF;
        tick();
        CLR_EDGES = '0;
        tick();
        chk("clr_all_flags", EDGE_FLAGS, 32'h0);
        chk("clr_all_port", PORT_OUT, 32'h0);

        // Clean rise of bit 0
        PIN_IN = 32'h1;
        repeat (6) tick();
        chk("rise_port_early", PORT_OUT, 32'h0);
        chk("rise_changed_early", {31'd0, CHANGED}, 32'h0);
        tick();
        chk("rise_port", PORT_OUT, 32'h1);
        chk("rise_changed", {31'd0, CHANGED}, 32'h1);
        chk("rise_flags", EDGE_FLAGS, 32'h1);
        tick();
        chk("rise_changed_off", {31'd0, CHANGED}, 32'h0);

        // Three-cycle glitch on bit 1
        pulses = 0;
        PIN_IN = 32'h3;
        repeat (3) tick();
        PIN_IN = 32'h1;
        repeat (12) tick();
        chk("glitch_pulses", 32'(pulses), 32'd0);
        chk("glitch_port", PORT_OUT, 32'h1);
        chk("glitch_flags", EDGE_FLAGS, 32'h1);

        // Bit 2 bounces in 2-cycle phases, then holds high
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            PIN_IN = ((i / 2) % 2 != 0) ? 32'h5 : 32'h1;
            tick();
        end
        PIN_IN = 32'h5;
        repeat (6) tick();
        chk("bounce_port_early", PORT_OUT, 32'h1);
        tick();
        chk("bounce_port", PORT_OUT, 32'h5);
        chk("bounce_changed", {31'd0, CHANGED}, 32'h1);
        repeat (3) tick();
        chk("bounce_pulses", 32'(pulses), 32'd1);
        chk("bounce_flags", EDGE_FLAGS, 32'h5);

        // Plain clear of flag 0
        CLR_EDGES = 32'h1;
        tick();
        CLR_EDGES = '0;
        chk("clr0_flags", EDGE_FLAGS, 32'h4);

        // Clear coinciding with a fresh rise of bit 0
        PIN_IN = 32'h4;
        repeat (8) tick();
        chk("drop0_port", PORT_OUT, 32'h4);
        PIN_IN = 32'h5;
        repeat (6) tick();
        CLR_EDGES = 32'h1;
        tick();
        CLR_EDGES = '0;
        chk("setclr_flags", EDGE_FLAGS, 32'h5);
        chk("setclr_changed", {31'd0, CHANGED}, 32'h1);
        chk("setclr_port", PORT_OUT, 32'h5);
        tick();
        chk("setclr_flags_hold", EDGE_FLAGS, 32'h5);

        // Falling edge of bit 0
        PIN_IN = 32'h4;
        repeat (7) tick();
        chk("fall0_port", PORT_OUT, 32'h4);
        chk("fall0_changed", {31'd0, CHANGED}, 32'h1);
        chk("fall0_flags", EDGE_FLAGS, 32'h5);

        // Reset two cycles into a settle
        pulses = 0;
        PIN_IN = 32'h6;
        repeat (5) tick();
        RST = 1'b0;
        #1;
        chk("midrst_port", PORT_OUT, 32'h0);
        chk("midrst_flags", EDGE_FLAGS, 32'h0);
        chk("midrst_changed", {31'd0, CHANGED}, 32'h0);
        repeat (3) tick();
        chk("midrst_pulses", 32'(pulses), 32'd0);
        RST = 1'b1;
        repeat (10) tick();
        chk("after_rst_port", PORT_OUT, 32'h6);
        chk("after_rst_flags", EDGE_FLAGS, 32'h6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
